// File: rtl/decode_issue_queue_if.sv
// Fetch-side and issue-side handshake bundle for decode_issue_queue.
// master = fetch/decode environment, slave = the queue itself.
interface decode_issue_queue_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int PC_W    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    flush;
  logic [FETCH_W-1:0]      fetch_valid;
  logic [32*FETCH_W-1:0]   fetch_instr;
  logic [PC_W*FETCH_W-1:0] fetch_pc;
  logic                    fetch_ready;
  logic                    issue_ready;
  logic [1:0]              issue_valid;
  logic [63:0]             issue_instr;
  logic [2*PC_W-1:0]       issue_pc;
  logic [CW-1:0]           count;

  modport master (
    output flush, fetch_valid, fetch_instr, fetch_pc, issue_ready,
    input  fetch_ready, issue_valid, issue_instr, issue_pc, count
  );

  modport slave (
    input  flush, fetch_valid, fetch_instr, fetch_pc, issue_ready,
    output fetch_ready, issue_valid, issue_instr, issue_pc, count
  );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular instruction buffer between fetch and decode; presents head (and head+1) to the decoders, 1-cycle write-to-issue latency.
// Slot1 pairing is compiled in with `define DUAL_ISSUE_EN; otherwise one instruction issues per cycle. Fetch stalls when free < FETCH_W.
module decode_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int PC_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  decode_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_W);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_issue_queue: DEPTH must be a power of 2 and at least 4");
  end
  if (FETCH_W < 1 || FETCH_W > 2) begin : g_bad_fetch_w
    $error("decode_issue_queue: FETCH_W must be 1 or 2");
  end

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          fetch_ready;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic          slot0_valid;
  logic          slot1_valid;

  // Readiness looks only at current occupancy, so a full queue cannot
  // refill in the same cycle it drains.
  assign fetch_ready = (count <= READY_MAX);
  assign slot0_valid = (count != '0);

  always_comb begin
    push_n = '0;
    if (fetch_ready) begin
      for (int i = 0; i < FETCH_W; i++) begin
        push_n = push_n + CW'(bus.fetch_valid[i]);
      end
    end
  end

  always_comb begin
    pop_n = '0;
    if (bus.issue_ready) begin
      pop_n = CW'(slot0_valid) + CW'(slot1_valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + pop_n[AW-1:0];
      tail  <= tail + push_n[AW-1:0];
      count <= count + push_n - pop_n;
    end
  end

  // Lanes are contiguous from lane 0, so lane i always lands at tail+i.
  always_ff @(posedge clk) begin
    if (!bus.flush && fetch_ready) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (bus.fetch_valid[i]) begin
          instr_mem[tail + AW'(i)] <= bus.fetch_instr[32*i +: 32];
          pc_mem[tail + AW'(i)]    <= bus.fetch_pc[PC_W*i +: PC_W];
        end
      end
    end
  end

`ifdef DUAL_ISSUE_EN
  typedef struct packed {
    logic       mem;
    logic       muldiv;
    logic       branch;
    logic       serial;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } pd_t;

  function automatic pd_t predecode(input logic [31:0] ins);
    pd_t        pd;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rtype;
    op    = ins[31:26];
    fn    = ins[5:0];
    rtype = (op == 6'h00);
    pd.rs = ins[25:21];
    pd.rt = ins[20:16];
    pd.mem    = op[5] && (op != 6'h2F);
    pd.muldiv = (rtype && fn >= 6'h10 && fn <= 6'h1B) || (op == 6'h1C);
    pd.branch = (op >= 6'h01 && op <= 6'h07) || (op >= 6'h14 && op <= 6'h17) ||
                (rtype && (fn == 6'h08 || fn == 6'h09));
    pd.serial = (op == 6'h10) || (op == 6'h2F) || (op == 6'h33) ||
                (rtype && (fn == 6'h0C || fn == 6'h0D || fn == 6'h0F ||
                           (fn >= 6'h30 && fn <= 6'h36)));
    pd.dest = 5'd0;
    if (rtype) begin
      pd.dest = ins[15:11];
    end else if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h26) ||
                 op == 6'h30 || op == 6'h38 || (op == 6'h10 && ins[25:21] == 5'd0)) begin
      pd.dest = ins[20:16];
    end else if (op == 6'h03 || (op == 6'h01 && ins[20:16] >= 5'h10 && ins[20:16] <= 5'h13)) begin
      pd.dest = 5'd31;
    end
    return pd;
  endfunction

  logic [AW-1:0] head1;
  pd_t           pd0;
  pd_t           pd1;
  logic          raw_hazard;
  logic          pair_ok;

  assign head1 = head + AW'(1);
  assign pd0   = predecode(instr_mem[head]);
  assign pd1   = predecode(instr_mem[head1]);

  // A register-0 destination never creates a dependency.
  assign raw_hazard = (pd0.dest != 5'd0) && (pd0.dest == pd1.rs || pd0.dest == pd1.rt);

  assign pair_ok = !raw_hazard && !(pd0.mem && pd1.mem) &&
                   !pd0.muldiv && !pd1.muldiv &&
                   !pd0.serial && !pd1.serial &&
                   !pd1.branch;

  assign slot1_valid = (count >= CW'(2)) && pair_ok;

  assign bus.issue_instr = {instr_mem[head1], instr_mem[head]};
  assign bus.issue_pc    = {pc_mem[head1], pc_mem[head]};
`else
  assign slot1_valid     = 1'b0;
  assign bus.issue_instr = {32'd0, instr_mem[head]};
  assign bus.issue_pc    = {{PC_W{1'b0}}, pc_mem[head]};
`endif

  assign bus.issue_valid = {slot1_valid, slot0_valid};
  assign bus.fetch_ready = fetch_ready;
  assign bus.count       = count;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));
  a_slot_order  : assert property (@(posedge clk) disable iff (!rst) slot1_valid |-> slot0_valid);
endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: pairing vector table, in-order scoreboard on every issued slot,
// and hand-written fill/wrap, flush and async-reset sequences.
module tb_decode_issue_queue;
  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int PW    = 32;
`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  decode_issue_queue_if #(.DEPTH(DEPTH), .FETCH_W(FW), .PC_W(PW)) bus ();

  decode_issue_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .PC_W(PW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  exp_dual;
  } vec_t;

  entry_t      sb[$];
  int          n_cmp  = 0;
  int          n_bad  = 0;
  logic [31:0] pc_seq = 32'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic ir, input logic fl);
    bus.fetch_valid = fv;
    bus.fetch_instr = {i1, i0};
    bus.fetch_pc    = {pc_seq + 32'd4, pc_seq};
    bus.issue_ready = ir;
    bus.flush       = fl;
  endtask

  task automatic pop_check(input int k);
    entry_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("slot%0d_instr", k), bus.issue_instr[32*k +: 32], e.instr);
      chk($sformatf("slot%0d_pc", k), bus.issue_pc[PW*k +: PW], e.pc);
    end
  endtask

  // Called at negedge with this cycle's inputs applied; checks outputs, updates model, advances one clock.
  task automatic tick();
    int   sz;
    logic rdy;
    sz  = sb.size();
    rdy = (sz <= DEPTH - FW);
    chk("count", bus.count, sz);
    chk("fetch_ready", bus.fetch_ready, rdy);
    chk("valid0", bus.issue_valid[0], sz >= 1);
    if (!(DUAL && sz >= 2)) chk("valid1", bus.issue_valid[1], 1'b0);
    if (bus.flush) begin
      sb.delete();
    end else begin
      if (bus.issue_ready) begin
        for (int k = 0; k < 2; k++) if (bus.issue_valid[k]) pop_check(k);
      end
      if (rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (bus.fetch_valid[i]) sb.push_back('{bus.fetch_instr[32*i +: 32], bus.fetch_pc[PW*i +: PW]});
        end
      end
    end
    pc_seq = pc_seq + 32'd8;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int t = 0; t < 2 * DEPTH && sb.size() > 0; t++) tick();
    chk("drain_empty", bus.count, 0);
  endtask

  initial begin
    vec_t vt[14];
    vt[0]  = '{32'h00221821, 32'h00862821, 2'b11}; // addu $3 / addu $5 independent
    vt[1]  = '{32'h00221821, 32'h00622023, 2'b01}; // RAW on rs
    vt[2]  = '{32'h8C220000, 32'hACA40004, 2'b01}; // lw / sw mem-mem
    vt[3]  = '{32'h10220003, 32'h00862821, 2'b11}; // beq + delay slot
    vt[4]  = '{32'h00221821, 32'h00220018, 2'b01}; // mult in slot1
    vt[5]  = '{32'h00862821, 32'h10220003, 2'b01}; // branch in slot1
    vt[6]  = '{32'h00221821, 32'h0000000C, 2'b01}; // syscall serial
    vt[7]  = '{32'h8C220000, 32'h00462821, 2'b01}; // load-use on rt dest
    vt[8]  = '{32'h8C220000, 32'h00862821, 2'b11}; // single mem
    vt[9]  = '{32'hACA40004, 32'h00862821, 2'b11}; // store has no dest
    vt[10] = '{32'h0C000010, 32'h03E62821, 2'b01}; // jal writes $31
    vt[11] = '{32'h00220021, 32'h00062821, 2'b11}; // dest $0 never conflicts
    vt[12] = '{32'h00221821, 32'h00832821, 2'b01}; // RAW on rt
    vt[13] = '{32'h00220018, 32'h00862821, 2'b01}; // mult in slot0

    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.issue_valid, 2'b00);
    chk("rst_ready", bus.fetch_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Pairing table: push the pair with decode stalled, inspect, then drain.
    foreach (vt[v]) begin
      drive(2'b11, vt[v].i0, vt[v].i1, 1'b0, 1'b0);
      tick();
      drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      chk($sformatf("pair%0d", v), bus.issue_valid, DUAL ? vt[v].exp_dual : 2'b01);
      drain();
    end

    // Independent pair issued back-to-back.
    drive(2'b11, 32'h00221821, 32'h00862821, 1'b1, 1'b0);
    tick();
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ind_cyc1", bus.issue_valid, DUAL ? 2'b11 : 2'b01);
    tick();
    chk("ind_cyc2", bus.issue_valid, DUAL ? 2'b00 : 2'b01);
    drain();

    // Fill with decode stalled until fetch_ready drops, then drain and wrap the tail.
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 32'h00221821, 32'h00862821, 1'b0, 1'b0);
      tick();
    end
    drive(2'b01, 32'h00062821, 32'd0, 1'b0, 1'b0);
    tick();
    chk("seven_count", bus.count, 7);
    chk("seven_ready", bus.fetch_ready, 1'b0);
    drive(2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0);
    tick();
    chk("ignored_count", bus.count, 7);
    drain();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 32'h8C220000 + i, 32'h00862821, 1'b0, 1'b0);
      tick();
    end
    chk("full_count", bus.count, DEPTH);
    chk("full_ready", bus.fetch_ready, 1'b0);
    drain();

    // Mixed traffic with simultaneous push/pop; order checked by scoreboard.
    for (int n = 0; n < 80; n++) begin
      logic [1:0] fv;
      int         a;
      int         b;
      fv = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
      a  = $urandom_range(0, 13);
      b  = $urandom_range(0, 13);
      drive(fv, vt[a].i0, vt[b].i1, 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end
    drain();

    // Flush beats a concurrent push and pop.
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 32'h00221821, 32'h00862821, 1'b0, 1'b0);
      tick();
    end
    chk("preflush_count", bus.count, 4);
    drive(2'b11, 32'h11111111, 32'h22222222, 1'b1, 1'b1);
    tick();
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush_count", bus.count, 0);
    chk("flush_valid", bus.issue_valid, 2'b00);
    drive(2'b11, 32'h8C220000, 32'h00462821, 1'b0, 1'b0);
    tick();
    drain();

    // Asynchronous reset in mid-cycle.
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 32'h00221821, 32'h00862821, 1'b0, 1'b0);
      tick();
    end
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_valid", bus.issue_valid, 2'b00);
    chk("arst_ready", bus.fetch_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(2'b11, 32'h00220021, 32'h00062821, 1'b0, 1'b0);
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
